angle_sweep_src: RTL and testbench

Stream source that produces a programmable arithmetic sweep of fixed-point angle words. It drives the avail/get/data handshake at the input end of the sine pipeline chain, i.e. it connects to the pre_* side of the first pipeline stage. It is used for self-test and table characterisation: software programs a start angle, step and sample count, pulses start, and the block emits exactly that many words, honouring downstream back-pressure.

---
 rtl/angle_sweep_src_if.sv | 21 ++
 rtl/angle_sweep_src.sv | 100 ++++++++++
 tb/tb_angle_sweep_src.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/angle_sweep_src_if.sv
// Angle-word stream link: avail/get/data handshake between a source and a consumer.
interface angle_sweep_src_if #(
    parameter int unsigned FXD_N = 32
);
    logic             post_avail;
    logic             post_get;
    logic [FXD_N-1:0] post_data;

    // Source side drives the word and its valid flag; consumer drives ready.
    modport master (
        output post_avail,
        output post_data,
        input  post_get
    );

    modport slave (
        input  post_avail,
        input  post_data,
        output post_get
    );
endinterface

// File: rtl/angle_sweep_src.sv
// Programmable arithmetic sweep source of fixed-point angle words.
// Emits count words start_val, start_val+step, ... honouring back-pressure,
// then pulses done for one cycle (also after an abort or a zero-count start).
module angle_sweep_src #(
    parameter int unsigned FXD_N = 32,
    parameter int unsigned CNT_N = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [FXD_N-1:0]          start_val,
    input  logic [FXD_N-1:0]          step_val,
    input  logic [CNT_N-1:0]          count,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_N-1:0]          sent_cnt,
    angle_sweep_src_if.master         post
);

    typedef enum logic [1:0] {
        IDLE_ST = 2'd0,
        RUN_ST  = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t           state;
    logic [FXD_N-1:0] step_q;
    logic [CNT_N-1:0] remaining_q;
    logic [FXD_N-1:0] data_q;
    logic             avail_q;

    // A word moves only when it is actually offered and the consumer takes it.
    logic xfer_c;
    assign xfer_c = avail_q && post.post_get;

    assign post.post_avail = avail_q;
    assign post.post_data  = data_q;

    // Sweep FSM with registered outputs; done/busy are set on the edge entering each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE_ST;
            step_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            avail_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE_ST: begin
                    busy <= 1'b0;
                    if (start) begin
                        sent_cnt <= '0;
                        busy     <= 1'b1;
                        if (count != '0) begin
                            step_q      <= step_val;
                            remaining_q <= count;
                            data_q      <= start_val;
                            avail_q     <= 1'b1;
                            state       <= RUN_ST;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE_ST;
                        end
                    end
                end

                RUN_ST: begin
                    if (xfer_c) begin
                        sent_cnt    <= sent_cnt + CNT_N'(1);
                        remaining_q <= remaining_q - CNT_N'(1);
                        data_q      <= FXD_N'(data_q + step_q);
                    end
                    // Last word taken or abort: drop valid and report completion.
                    if ((xfer_c && (remaining_q == CNT_N'(1))) || abort) begin
                        avail_q <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE_ST;
                    end
                end

                DONE_ST: begin
                    busy  <= 1'b0;
                    state <= IDLE_ST;
                end

                default: begin
                    avail_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE_ST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_angle_sweep_src.sv
// Directed bench for angle_sweep_src: inputs driven and outputs sampled on the falling edge.
module tb_angle_sweep_src;

    localparam int unsigned FXD_N = 32;
    localparam int unsigned CNT_N = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [FXD_N-1:0] start_val;
    logic [FXD_N-1:0] step_val;
    logic [CNT_N-1:0] count;
    logic             busy;
    logic             done;
    logic [CNT_N-1:0] sent_cnt;

    int checks;
    int errors;

    angle_sweep_src_if #(.FXD_N(FXD_N)) bus ();

    angle_sweep_src #(.FXD_N(FXD_N), .CNT_N(CNT_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .start_val (start_val),
        .step_val  (step_val),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt),
        .post      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start_val = '0; step_val = '0; count = '0; bus.post_get = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.post_avail, busy, done, sent_cnt, bus.post_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got avail=%0b busy=%0b done=%0b sent=%0d data=%h want all zero",
                     bus.post_avail, busy, done, sent_cnt, bus.post_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [FXD_N-1:0] exp_w [3];
        exp_w[0] = 32'h10; exp_w[1] = 32'h14; exp_w[2] = 32'h18;
        start = 1'b1; start_val = 32'h10; step_val = 32'h4; count = 16'd3; bus.post_get = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.post_avail !== 1'b1 || bus.post_data !== exp_w[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_word%0d got avail=%0b data=%h busy=%0b want 1 %h 1",
                         i, bus.post_avail, bus.post_data, busy, exp_w[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || bus.post_avail !== 1'b0 || sent_cnt !== 16'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done got done=%0b avail=%0b sent=%0d busy=%0b want 1 0 3 1",
                     done, bus.post_avail, sent_cnt, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sent_cnt !== 16'd3) begin
            errors++;
            $display("FAIL basic_idle got done=%0b busy=%0b sent=%0d want 0 0 3", done, busy, sent_cnt);
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        xfers = 0;
        start = 1'b1; start_val = 32'h100; step_val = 32'h20; count = 16'd2; bus.post_get = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.post_avail !== 1'b1 || bus.post_data !== 32'h100 || sent_cnt !== 16'd0) begin
                errors++;
                $display("FAIL stall_cycle%0d got avail=%0b data=%h sent=%0d want 1 00000100 0",
                         i, bus.post_avail, bus.post_data, sent_cnt);
            end
            @(negedge clk);
        end
        bus.post_get = 1'b1;
        checks++;
        if (bus.post_data !== 32'h100) begin
            errors++;
            $display("FAIL bp_word0 got %h want 00000100", bus.post_data);
        end
        if (bus.post_avail === 1'b1) xfers++;
        @(negedge clk);
        checks++;
        if (bus.post_avail !== 1'b1 || bus.post_data !== 32'h120) begin
            errors++;
            $display("FAIL bp_word1 got avail=%0b data=%h want 1 00000120", bus.post_avail, bus.post_data);
        end
        if (bus.post_avail === 1'b1) xfers++;
        @(negedge clk);
        checks++;
        if (bus.post_avail !== 1'b0 || done !== 1'b1 || sent_cnt !== 16'd2 || xfers != 2) begin
            errors++;
            $display("FAIL bp_done got avail=%0b done=%0b sent=%0d xfers=%0d want 0 1 2 2",
                     bus.post_avail, done, sent_cnt, xfers);
        end
        bus.post_get = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        start = 1'b1; start_val = 32'hFFFF_FFFE; step_val = 32'h3; count = 16'd2; bus.post_get = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus.post_avail !== 1'b1 || bus.post_data !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_word0 got avail=%0b data=%h want 1 fffffffe", bus.post_avail, bus.post_data);
        end
        @(negedge clk);
        checks++;
        if (bus.post_avail !== 1'b1 || bus.post_data !== 32'h0000_0001) begin
            errors++;
            $display("FAIL wrap_word1 got avail=%0b data=%h want 1 00000001", bus.post_avail, bus.post_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sent_cnt !== 16'd2) begin
            errors++;
            $display("FAIL wrap_done got done=%0b sent=%0d want 1 2", done, sent_cnt);
        end
        bus.post_get = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        start = 1'b1; start_val = 32'h55; step_val = 32'h1; count = 16'd0; bus.post_get = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus.post_avail !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || sent_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_done got avail=%0b done=%0b busy=%0b sent=%0d want 0 1 1 0",
                     bus.post_avail, done, busy, sent_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.post_avail !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got avail=%0b done=%0b busy=%0b want 0 0 0", bus.post_avail, done, busy);
        end
        bus.post_get = 1'b0;
    endtask

    task automatic test_abort();
        int done_pulses;
        done_pulses = 0;
        start = 1'b1; start_val = 32'h0; step_val = 32'h1; count = 16'd10; bus.post_get = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Start with count 0 during the run: must be ignored (would otherwise end the sweep).
        start = 1'b1; start_val = 32'hDEAD; count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus.post_avail !== 1'b1 || bus.post_data !== 32'h2 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_ignored got avail=%0b data=%h done=%0b want 1 00000002 0",
                     bus.post_avail, bus.post_data, done);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (done === 1'b1) done_pulses++;
        checks++;
        if (sent_cnt !== 16'd4 || bus.post_avail !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_end got sent=%0d avail=%0b done=%0b want 4 0 1", sent_cnt, bus.post_avail, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_pulses++;
        end
        checks++;
        if (done_pulses != 1 || busy !== 1'b0 || sent_cnt !== 16'd4 || bus.post_avail !== 1'b0) begin
            errors++;
            $display("FAIL abort_single_done got pulses=%0d busy=%0b sent=%0d avail=%0b want 1 0 4 0",
                     done_pulses, busy, sent_cnt, bus.post_avail);
        end
        bus.post_get = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        start = 1'b1; start_val = 32'h40; step_val = 32'h1; count = 16'd5; bus.post_get = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bus.post_get = 1'b0;
        checks++;
        if (sent_cnt !== 16'd1 || bus.post_data !== 32'h41) begin
            errors++;
            $display("FAIL midrst_pre got sent=%0d data=%h want 1 00000041", sent_cnt, bus.post_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.post_avail !== 1'b0 || busy !== 1'b0 || sent_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_async got avail=%0b busy=%0b sent=%0d want 0 0 0",
                     bus.post_avail, busy, sent_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.post_avail !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got avail=%0b busy=%0b want 0 0", bus.post_avail, busy);
        end
        start = 1'b1; start_val = 32'h77; step_val = 32'h2; count = 16'd2; bus.post_get = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus.post_avail !== 1'b1 || bus.post_data !== 32'h77) begin
            errors++;
            $display("FAIL midrst_word0 got avail=%0b data=%h want 1 00000077", bus.post_avail, bus.post_data);
        end
        @(negedge clk);
        checks++;
        if (bus.post_data !== 32'h79) begin
            errors++;
            $display("FAIL midrst_word1 got %h want 00000079", bus.post_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sent_cnt !== 16'd2) begin
            errors++;
            $display("FAIL midrst_done got done=%0b sent=%0d want 1 2", done, sent_cnt);
        end
        bus.post_get = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_abort();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
